// File: rtl/gcn_pkg.sv
// Shared GCN definitions: argmax FSM state encoding and default datapath widths
// common to the combination and argmax stages.
package gcn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  localparam int GCN_DOT_PROD_WIDTH    = 16;
  localparam int GCN_MAX_ADDRESS_WIDTH = 2;
  localparam int GCN_FEATURE_ROWS      = 6;
  localparam int GCN_WEIGHT_COLS       = 3;

endpackage

// File: rtl/gcn_argmax_block_if.sv
// Bus between the combination stage (master) and the argmax block (slave):
// start/finish handshake, row-addressed result memory read, and per-node classes.
interface gcn_argmax_block_if
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS      = GCN_FEATURE_ROWS,
  parameter int WEIGHT_COLS       = GCN_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH    = GCN_DOT_PROD_WIDTH,
  parameter int MAX_ADDRESS_WIDTH = GCN_MAX_ADDRESS_WIDTH,
  parameter int FEATURE_WIDTH     = $clog2(FEATURE_ROWS)
);

  logic                                                done_comb;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]          fm_wm_adj_out;
  logic [FEATURE_WIDTH-1:0]                            read_row_adj;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]      max_addi_answer;
  logic                                                done;

  modport master (
    output done_comb,
    output fm_wm_adj_out,
    input  read_row_adj,
    input  max_addi_answer,
    input  done
  );

  modport slave (
    input  done_comb,
    input  fm_wm_adj_out,
    output read_row_adj,
    output max_addi_answer,
    output done
  );

endinterface

// File: rtl/gcn_row_argmax.sv
// Combinational argmax of one result row: linear compare chain, unsigned,
// a later column only wins when strictly greater so ties keep the lowest index.
module gcn_row_argmax
  import gcn_pkg::*;
#(
  parameter int WEIGHT_COLS       = GCN_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH    = GCN_DOT_PROD_WIDTH,
  parameter int MAX_ADDRESS_WIDTH = GCN_MAX_ADDRESS_WIDTH
) (
  input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] i_row,
  output logic [MAX_ADDRESS_WIDTH-1:0]               o_idx
);

  logic [DOT_PROD_WIDTH-1:0]    w_best_val [WEIGHT_COLS];
  logic [MAX_ADDRESS_WIDTH-1:0] w_best_idx [WEIGHT_COLS];

  assign w_best_val[0] = i_row[0];
  assign w_best_idx[0] = '0;

  for (genvar gi = 1; gi < WEIGHT_COLS; gi++) begin : g_chain
    logic w_take;
    assign w_take        = i_row[gi] > w_best_val[gi-1];
    assign w_best_val[gi] = w_take ? i_row[gi] : w_best_val[gi-1];
    assign w_best_idx[gi] = w_take ? MAX_ADDRESS_WIDTH'(gi) : w_best_idx[gi-1];
  end

  assign o_idx = w_best_idx[WEIGHT_COLS-1];

endmodule

// File: rtl/gcn_argmax_block.sv
// Final GCN classification stage: after done_comb, scans the result memory one
// row per cycle, latches each row's argmax class, then holds done until released.
module gcn_argmax_block
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS      = GCN_FEATURE_ROWS,
  parameter int WEIGHT_COLS       = GCN_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH    = GCN_DOT_PROD_WIDTH,
  parameter int MAX_ADDRESS_WIDTH = GCN_MAX_ADDRESS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  gcn_argmax_block_if.slave    bus
);

  localparam int FEATURE_WIDTH = $clog2(FEATURE_ROWS);

  argmax_state_t                                  r_state;
  logic [FEATURE_WIDTH-1:0]                       r_row_cnt;
  logic                                           r_done;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] r_answers;
  logic [MAX_ADDRESS_WIDTH-1:0]                   w_row_idx;

  gcn_row_argmax #(
    .WEIGHT_COLS       (WEIGHT_COLS),
    .DOT_PROD_WIDTH    (DOT_PROD_WIDTH),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_row_argmax (
    .i_row (bus.fm_wm_adj_out),
    .o_idx (w_row_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_done    <= 1'b0;
      r_answers <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.done_comb) begin
            r_state   <= SCAN;
            r_row_cnt <= '0;
          end
        end
        SCAN: begin
          for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (r_row_cnt == FEATURE_WIDTH'(i)) r_answers[i] <= w_row_idx;
          end
          if (r_row_cnt == FEATURE_WIDTH'(FEATURE_ROWS - 1)) r_state <= DONE;
          else r_row_cnt <= r_row_cnt + 1'b1;
        end
        DONE: begin
          // done always rises for at least one cycle, even if done_comb already dropped
          r_done <= !r_done || bus.done_comb;
          if (!bus.done_comb) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.read_row_adj    = (r_state == SCAN) ? r_row_cnt : '0;
  assign bus.max_addi_answer = r_answers;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_gcn_argmax_block.sv
// Directed bench for gcn_argmax_block: reset, basic scan, extreme values,
// done handshake, asynchronous reset mid-scan and a one-cycle done_comb pulse.
module tb_gcn_argmax_block;
  import gcn_pkg::*;

  localparam int FR  = 6;
  localparam int WC  = 3;
  localparam int DPW = 16;
  localparam int MAW = 2;
  localparam int FW  = $clog2(FR);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [0:WC-1][DPW-1:0] mem     [FR];
  logic [MAW-1:0]         exp_ans [FR];

  gcn_argmax_block_if #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DPW), .MAX_ADDRESS_WIDTH(MAW)
  ) bus ();

  gcn_argmax_block #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DPW), .MAX_ADDRESS_WIDTH(MAW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // result memory with combinational read, as the combination stage presents it
  always_comb begin
    bus.fm_wm_adj_out = '0;
    if (int'(bus.read_row_adj) < FR) bus.fm_wm_adj_out = mem[int'(bus.read_row_adj)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_row"}, 32'(bus.read_row_adj), 32'd0);
    for (int i = 0; i < FR; i++)
      chk($sformatf("%s_ans%0d", tag, i), 32'(bus.max_addi_answer[i]), 32'd0);
  endtask

  task automatic chk_answers(input string tag);
    for (int i = 0; i < FR; i++)
      chk($sformatf("%s_ans%0d", tag, i), 32'(bus.max_addi_answer[i]), 32'(exp_ans[i]));
  endtask

  // raise done_comb from IDLE; pulse drops it again right after the starting edge
  task automatic run_scan(input string tag, input bit pulse);
    bus.done_comb = 1'b1;
    for (int j = 0; j < FR + 3; j++) begin
      step();
      if (j == 0 && pulse) bus.done_comb = 1'b0;
      chk($sformatf("%s_row%0d", tag, j), 32'(bus.read_row_adj), (j < FR) ? 32'(j) : 32'd0);
      chk($sformatf("%s_done%0d", tag, j), 32'(bus.done),
          pulse ? 32'(j == FR + 1) : 32'(j >= FR + 1));
    end
    chk_answers(tag);
  endtask

  task automatic load_basic();
    mem[0] = {16'd5, 16'd9, 16'd2};  exp_ans[0] = 2'd1;
    mem[1] = {16'd1, 16'd0, 16'd7};  exp_ans[1] = 2'd2;
    mem[2] = {16'd8, 16'd8, 16'd8};  exp_ans[2] = 2'd0;
    mem[3] = {16'd0, 16'd3, 16'd3};  exp_ans[3] = 2'd1;
    mem[4] = {16'd4, 16'd1, 16'd0};  exp_ans[4] = 2'd0;
    mem[5] = {16'd2, 16'd6, 16'd1};  exp_ans[5] = 2'd1;
  endtask

  task automatic load_extreme();
    mem[0] = {16'hFFFF, 16'hFFFE, 16'h0000};  exp_ans[0] = 2'd0;
    mem[1] = {16'h0000, 16'hFFFF, 16'hFFFF};  exp_ans[1] = 2'd1;
    mem[2] = {16'd1, 16'd2, 16'd3};           exp_ans[2] = 2'd2;
    mem[3] = {16'd3, 16'd2, 16'd1};           exp_ans[3] = 2'd0;
    mem[4] = {16'd7, 16'd7, 16'd9};           exp_ans[4] = 2'd2;
    mem[5] = {16'd0, 16'd0, 16'd0};           exp_ans[5] = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.done_comb = 1'b0;
    load_basic();

    // reset state, then idle with done_comb low
    step();
    step();
    chk_cleared("rst");
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("idle_done%0d", k), 32'(bus.done), 32'd0);
      chk($sformatf("idle_row%0d", k), 32'(bus.read_row_adj), 32'd0);
    end
    chk_cleared("idle");

    // basic scan with done_comb held high
    run_scan("basic", 1'b0);

    // held done_comb: no rescan even though the memory contents change
    load_extreme();
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("hold_done%0d", k), 32'(bus.done), 32'd1);
      chk($sformatf("hold_row%0d", k), 32'(bus.read_row_adj), 32'd0);
    end
    load_basic();
    chk_answers("hold");
    bus.done_comb = 1'b0;
    step();
    chk("drop_done", 32'(bus.done), 32'd0);
    step();
    chk("drop_done2", 32'(bus.done), 32'd0);

    // fresh scan with extreme values overwrites every entry
    load_extreme();
    run_scan("max", 1'b0);
    bus.done_comb = 1'b0;
    step();
    step();

    // asynchronous reset while row 3 is on the bus
    load_basic();
    bus.done_comb = 1'b1;
    step();
    step();
    step();
    step();
    chk("mid_row", 32'(bus.read_row_adj), 32'd3);
    chk("mid_ans0", 32'(bus.max_addi_answer[0]), 32'd1);
    #2 reset = 1'b0;
    #1 chk_cleared("async");
    bus.done_comb = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_cleared("post_rst");
    run_scan("rescan", 1'b0);
    bus.done_comb = 1'b0;
    step();
    step();

    // one-cycle done_comb pulse still completes the scan
    load_extreme();
    run_scan("pulse", 1'b1);
    step();
    chk("pulse_idle_done", 32'(bus.done), 32'd0);
    chk("pulse_idle_row", 32'(bus.read_row_adj), 32'd0);
    chk_answers("pulse_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
